// File: rtl/lsu_mem_bridge.sv
// Load/store bridge: converts one byte/half/word core access into a single word-addressed
// request on a synchronous data RAM with a req/ready handshake. The core is stalled until the
// access completes. Loads return the aligned and sign- or zero-extended value.
module lsu_mem_bridge #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_rd_e,
  input  logic              d_wr_e,
  input  logic              sb,
  input  logic              sh,
  input  logic              sw,
  input  logic              lb,
  input  logic              lh,
  input  logic              lw,
  input  logic              lbu,
  input  logic              lhu,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  state_e              state_q, state_d;
  size_e               ld_size_q, ld_size_d;
  logic                ld_signed_q, ld_signed_d;
  logic [1:0]          off_q, off_d;
  logic [7:0]          counter_q, counter_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                bus_err_q, bus_err_d;

  // Request decode
  logic        req, is_store, is_word, is_half, req_signed;
  size_e       req_size;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] rd_shift, rd_fmt;

  // Only the word-address bits of addr reach the RAM.
  logic unused_addr;
  assign unused_addr = ^addr[31:ADDR_W+2];

  // Decode request type, size priority, lane enables and replicated store data.
  always_comb begin
    req        = d_rd_e | d_wr_e;
    is_store   = d_wr_e;  // store wins when both strobes are set
    is_word    = 1'b0;
    is_half    = 1'b0;
    req_signed = 1'b0;
    req_be     = 4'b1111;
    req_wdata  = wdata;
    if (is_store) begin
      is_word = sw;
      is_half = ~sw & sh;
    end else begin
      is_word = lw;
      is_half = ~lw & (lh | lhu);
    end
    if (is_word) begin
      req_size = SzWord;
    end else if (is_half) begin
      req_size = SzHalf;
    end else begin
      req_size = SzByte;
    end
    // lh/lb take precedence over their unsigned twins if both are strobed
    req_signed = is_half ? lh : (~is_word & lb);
    if (is_store) begin
      unique case (req_size)
        SzByte: begin
          req_be    = 4'b0001 << addr[1:0];
          req_wdata = {4{wdata[7:0]}};
        end
        SzHalf: begin
          req_be    = addr[1] ? 4'b1100 : 4'b0011;
          req_wdata = {2{wdata[15:0]}};
        end
        default: begin
          req_be    = 4'b1111;
          req_wdata = wdata;
        end
      endcase
    end
    misalign = req & ((is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00)));
  end

  // Align and extend the returned RAM word for the latched load type.
  always_comb begin
    rd_shift = mem_rdata >> {off_q, 3'b000};
    unique case (ld_size_q)
      SzByte:  rd_fmt = {{24{ld_signed_q & rd_shift[7]}}, rd_shift[7:0]};
      SzHalf:  rd_fmt = {{16{ld_signed_q & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_fmt = mem_rdata;
    endcase
  end

  // Next-state logic for the access FSM and its latched request fields.
  always_comb begin
    state_d     = state_q;
    ld_size_d   = ld_size_q;
    ld_signed_d = ld_signed_q;
    off_d       = off_q;
    counter_d   = counter_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    bus_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req && !misalign) begin
          state_d     = StAccess;
          mem_req_d   = 1'b1;
          mem_we_d    = is_store;
          mem_be_d    = req_be;
          mem_addr_d  = addr[ADDR_W+1:2];
          mem_wdata_d = req_wdata;
          off_d       = addr[1:0];
          ld_size_d   = req_size;
          ld_signed_d = req_signed;
          counter_d   = 8'd0;
        end
      end
      StAccess: begin
        if (mem_ready) begin
          state_d   = StDone;
          mem_req_d = 1'b0;
          rdata_d   = mem_we_q ? 32'd0 : rd_fmt;
        end else if (counter_q == 8'(TIMEOUT - 1)) begin
          state_d   = StDone;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          rdata_d   = 32'd0;
        end else begin
          counter_d = counter_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ld_size_q   <= SzWord;
      ld_signed_q <= 1'b0;
      off_q       <= 2'd0;
      counter_q   <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_size_q   <= ld_size_d;
      ld_signed_q <= ld_signed_d;
      off_q       <= off_d;
      counter_q   <= counter_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Outputs; a misaligned request forces rdata to zero.
  always_comb begin
    stall     = req & ~misalign & (state_q != StDone);
    rdata     = misalign ? 32'd0 : rdata_q;
    bus_err   = bus_err_q;
    mem_req   = mem_req_q;
    mem_we    = mem_we_q;
    mem_be    = mem_be_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
  end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed bench for lsu_mem_bridge: inputs change and outputs are sampled on the falling edge.
module tb_lsu_mem_bridge;

  localparam int unsigned ADDR_W = 10;

  // Strobe vector order: {sb, sh, sw, lb, lh, lw, lbu, lhu}
  localparam logic [7:0] S_SB  = 8'h80;
  localparam logic [7:0] S_SH  = 8'h40;
  localparam logic [7:0] S_SW  = 8'h20;
  localparam logic [7:0] S_LB  = 8'h10;
  localparam logic [7:0] S_LH  = 8'h08;
  localparam logic [7:0] S_LW  = 8'h04;
  localparam logic [7:0] S_LBU = 8'h02;
  localparam logic [7:0] S_LHU = 8'h01;

  logic              clk = 1'b0;
  logic              rst;
  logic              d_rd_e, d_wr_e;
  logic [7:0]        strb;
  logic [31:0]       addr, wdata, rdata;
  logic              stall, misalign, bus_err;
  logic              mem_req, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_mem_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .d_rd_e    (d_rd_e),
    .d_wr_e    (d_wr_e),
    .sb        (strb[7]),
    .sh        (strb[6]),
    .sw        (strb[5]),
    .lb        (strb[4]),
    .lh        (strb[3]),
    .lw        (strb[2]),
    .lbu       (strb[1]),
    .lhu       (strb[0]),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    d_rd_e    = 1'b0;
    d_wr_e    = 1'b0;
    strb      = 8'h00;
    mem_ready = 1'b0;
  endtask

  // One complete access: request, optional wait cycles, ready, DONE, back to idle.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [7:0] s, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] mrd, input int waits,
                            input logic [9:0] exp_addr, input logic [3:0] exp_be,
                            input logic exp_we, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_rdata);
    d_rd_e = rd;
    d_wr_e = wr;
    strb   = s;
    addr   = a;
    wdata  = wd;
    #1;
    check_eq({tag, ".stall_idle"}, 32'(stall), 32'd1);
    @(negedge clk);
    check_eq({tag, ".req"}, 32'(mem_req), 32'd1);
    check_eq({tag, ".addr"}, 32'(mem_addr), 32'(exp_addr));
    check_eq({tag, ".be"}, 32'(mem_be), 32'(exp_be));
    check_eq({tag, ".we"}, 32'(mem_we), 32'(exp_we));
    if (exp_we) check_eq({tag, ".wdata"}, mem_wdata, exp_wdata);
    check_eq({tag, ".stall_acc"}, 32'(stall), 32'd1);
    for (int i = 0; i < waits; i++) begin
      mem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      check_eq({tag, ".stall_wait"}, 32'(stall), 32'd1);
    end
    mem_ready = 1'b1;
    mem_rdata = mrd;
    @(negedge clk);
    mem_ready = 1'b0;
    check_eq({tag, ".stall_done"}, 32'(stall), 32'd0);
    check_eq({tag, ".req_done"}, 32'(mem_req), 32'd0);
    check_eq({tag, ".rdata"}, rdata, exp_rdata);
    check_eq({tag, ".bus_err"}, 32'(bus_err), 32'd0);
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    rst       = 1'b1;
    addr      = 32'd0;
    wdata     = 32'd0;
    mem_rdata = 32'd0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check_eq("rst.req", 32'(mem_req), 32'd0);
    check_eq("rst.be", 32'(mem_be), 32'd0);
    check_eq("rst.addr", 32'(mem_addr), 32'd0);
    check_eq("rst.rdata", rdata, 32'd0);
    check_eq("rst.stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_access("sw10", 1'b0, 1'b1, S_SW, 32'h10, 32'hDEADBEEF, 32'h0, 0,
               10'd4, 4'b1111, 1'b1, 32'hDEADBEEF, 32'h0);
    run_access("lb13", 1'b1, 1'b0, S_LB, 32'h13, 32'h0, 32'h80FF_FF00, 0,
               10'd4, 4'b1111, 1'b0, 32'h0, 32'hFFFF_FF80);
    run_access("lbu13", 1'b1, 1'b0, S_LBU, 32'h13, 32'h0, 32'h80FF_FF00, 0,
               10'd4, 4'b1111, 1'b0, 32'h0, 32'h0000_0080);
    run_access("sh6", 1'b0, 1'b1, S_SH, 32'h6, 32'h1234ABCD, 32'h0, 0,
               10'd1, 4'b1100, 1'b1, 32'hABCD_ABCD, 32'h0);
    run_access("lhu6", 1'b1, 1'b0, S_LHU, 32'h6, 32'h0, 32'hABCD_0000, 0,
               10'd1, 4'b1111, 1'b0, 32'h0, 32'h0000_ABCD);
    run_access("sb11", 1'b0, 1'b1, S_SB, 32'h11, 32'h0000_005A, 32'h0, 1,
               10'd4, 4'b0010, 1'b1, 32'h5A5A_5A5A, 32'h0);
    run_access("lh2", 1'b1, 1'b0, S_LH, 32'h2, 32'h0, 32'h8001_1234, 0,
               10'd0, 4'b1111, 1'b0, 32'h0, 32'hFFFF_8001);
    run_access("lw24", 1'b1, 1'b0, S_LW, 32'h24, 32'h0, 32'hCAFE_F00D, 2,
               10'd9, 4'b1111, 1'b0, 32'h0, 32'hCAFE_F00D);
    // Both strobes: store wins
    run_access("both", 1'b1, 1'b1, S_SW | S_LW, 32'h8, 32'h0BAD_F00D, 32'h1111_1111, 0,
               10'd2, 4'b1111, 1'b1, 32'h0BAD_F00D, 32'h0);

    // Misaligned word load: suppressed entirely
    d_rd_e = 1'b1;
    strb   = S_LW;
    addr   = 32'h2;
    #1;
    check_eq("mis.flag", 32'(misalign), 32'd1);
    check_eq("mis.stall", 32'(stall), 32'd0);
    check_eq("mis.rdata", rdata, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_eq("mis.req", 32'(mem_req), 32'd0);
    end
    // Misaligned half store
    d_rd_e = 1'b0;
    d_wr_e = 1'b1;
    strb   = S_SH;
    addr   = 32'h5;
    #1;
    check_eq("mis_sh.flag", 32'(misalign), 32'd1);
    @(negedge clk);
    check_eq("mis_sh.req", 32'(mem_req), 32'd0);
    idle_inputs();
    #1;
    check_eq("mis.clear", 32'(misalign), 32'd0);
    @(negedge clk);

    // Timeout: ready never arrives
    d_rd_e = 1'b1;
    strb   = S_LW;
    addr   = 32'h20;
    cnt    = 0;
    @(negedge clk);
    while (stall && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check_eq("to.cycles", 32'(cnt), 32'd15);
    check_eq("to.bus_err", 32'(bus_err), 32'd1);
    check_eq("to.rdata", rdata, 32'd0);
    check_eq("to.req", 32'(mem_req), 32'd0);
    idle_inputs();
    @(negedge clk);
    check_eq("to.bus_err_clr", 32'(bus_err), 32'd0);

    // Reset mid-access abandons it; stray ready afterwards is ignored
    d_rd_e = 1'b1;
    strb   = S_LW;
    addr   = 32'h40;
    @(negedge clk);
    check_eq("ra.req_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    check_eq("ra.req_after", 32'(mem_req), 32'd0);
    rst       = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_ready = 1'b0;
    check_eq("ra.stray_req", 32'(mem_req), 32'd0);
    check_eq("ra.stray_rdata", rdata, 32'd0);
    check_eq("ra.stray_err", 32'(bus_err), 32'd0);
    run_access("ra.lw", 1'b1, 1'b0, S_LW, 32'h44, 32'h0, 32'h1357_9BDF, 0,
               10'd17, 4'b1111, 1'b0, 32'h0, 32'h1357_9BDF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
